imem_loader: RTL
================

Name: imem_loader

Overview:
- Instruction-side counterpart of the 4-bit core, which consumes a 10-bit `instruct` word addressed by its 8-bit PC.
- This block is the producer of those words. Off-chip, a tester shifts program words in serially, MSB first. The block writes them into an on-chip instruction store and holds the core in reset while loading.
- Afterwards it releases the core and returns the word at the core's PC every cycle.

Parameters:
- INSTR_W, 10, instruction word width
- ADDR_W, 8, PC / store address width
- DEPTH, 256, store entries (must be ≤ 2**ADDR_W)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (reset==0 resets)
- load_en  in  1  1 = load mode requested
- sdata  in  1  serial instruction bit, MSB first
- svalid  in  1  sdata qualifier; one bit consumed per cycle with svalid=1
- pc  in  ADDR_W  fetch address from core
- instr  out  INSTR_W  instruction for core
- core_reset  out  1  active-high reset to core
- word_count  out  ADDR_W+1  words written since last load start
- overflow  out  1  sticky; a complete word arrived with store full

Behaviour:
- **States:** IDLE, LOAD, RUN (enum in package).
- **Reset values (async, reset==0):**
  - state=IDLE, core_reset=1, word_count=0, overflow=0, bit counter=0, shift register=0, instr=0.
  - Store contents are not reset.
- **IDLE:**
  - core_reset=1.
  - load_en=1 → LOAD next cycle.
  - Otherwise stay.
  - IDLE never goes directly to RUN.
- **Entry to LOAD (from IDLE or RUN):** word_count←0, bit counter←0, overflow←0, core_reset←1 (same edge).
- **LOAD, svalid=1:**
  - shreg←{shreg[INSTR_W-2:0], sdata}; bitcnt++.
  - When bitcnt==INSTR_W-1 with svalid=1, the word is complete. On that same edge:
    - store[word_count]←{shreg[INSTR_W-2:0], sdata};
    - word_count++;
    - bitcnt←0.
  - Back-to-back words need no idle cycle.
  - svalid=0 holds all state.
- **Store full:** if a word completes with word_count==DEPTH, the write is dropped, word_count holds, and overflow←1 (sticky until next LOAD entry).
- **load_en falls in LOAD:**
  - Next state RUN.
  - A partial word (bitcnt≠0) is discarded; bitcnt←0.
  - If svalid=1 in that same cycle, the bit is ignored.
- **RUN:**
  - core_reset←0 on the edge entering RUN, so the core sees its first non-reset cycle one cycle after load_en falls.
  - load_en=1 → LOAD (reload; core_reset reasserted that edge).
  - sdata/svalid ignored.
- **instr (combinational from pc and state):**
  - instr = (state==RUN && pc < word_count) ? store[pc] : 0.
  - Word 0 reads as a no-effect instruction to the core; unloaded addresses are therefore safe.
- **Reset mid-LOAD:** everything returns to IDLE, the partial word is lost, and the store keeps previously written words. word_count=0 makes them unreadable.
- **Width rule:** word_count has ADDR_W+1 bits so DEPTH=256 is representable. The comparison with pc zero-extends pc.

Decomposition:
- **Package `imem_pkg`:**
  - state enum `loader_state_t` {IDLE, LOAD, RUN};
  - localparams INSTR_W=10, ADDR_W=8, DEPTH=256;
  - `BITCNT_W = $clog2(INSTR_W)`.
- **Sub-module `imem_array`:** DEPTH×INSTR_W, one synchronous write port (we, waddr, wdata), one asynchronous read port (raddr → rdata), no reset.
- **Top:** FSM, shift register, bit counter, word counter, overflow flag, instr gating.

Test Plan:
1. **Reset/idle:** hold reset=0 for 3 cycles, release with load_en=0 → core_reset=1, instr=0, word_count=0, state stays IDLE.
2. **Basic load and run:**
   - Stimulus: load_en=1; shift 10'b1010_0011_01 then 10'b0000_1111_00 back-to-back; drop load_en.
   - Response: word_count=2; core_reset=0 one cycle after load_en falls; pc=0 → instr=0x28D; pc=1 → instr=0x03C; pc=2 → instr=0.
3. **Gapped svalid and partial word:**
   - Stimulus: word 0x155 shifted with svalid low every other cycle; then 4 bits; drop load_en.
   - Response: word_count=1, store[0]=0x155, partial discarded, pc=1 → 0.
4. **Overflow:**
   - Stimulus: DEPTH=4 build; shift 5 words 0x001..0x005.
   - Response: word_count=4, overflow=1, pc=3 → 0x004, 0x005 not stored.
   - Reload (load_en 0→1) clears overflow and word_count.
5. **Reload from RUN:**
   - Stimulus: after scenario 2, raise load_en.
   - Response: core_reset=1 on the next edge; instr=0 for all pc while in LOAD; new single word 0x3FF at pc=0 after RUN.
6. **Async reset mid-word:**
   - Stimulus: assert reset=0 between clock edges after 5 bits.
   - Response: immediately core_reset=1, state IDLE, word_count=0, instr=0; after a new load, the first word is aligned correctly (no leftover bits).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-store loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

  localparam int INSTR_W  = 10;
  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 256;
  localparam int BITCNT_W = $clog2(INSTR_W);

  // IDLE: core held in reset, store untouched.
  // LOAD: serial words written to the store, core held in reset.
  // RUN : core released, store read at the core's PC.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction store: DEPTH x INSTR_W, one sync write port, one async read port, no reset.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; a write is accepted on every cycle we=1.
//
// Ports:
//   clk          write clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata  asynchronous read port
module imem_array
  import imem_pkg::*;
#(
  parameter int INSTR_W = imem_pkg::INSTR_W,
  parameter int ADDR_W  = imem_pkg::ADDR_W,
  parameter int DEPTH   = imem_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  // Only the low address bits that select an entry are used; the loader
  // never presents an address at or beyond DEPTH when it matters.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[raddr[AW-1:0]];

endmodule

// File: rtl/imem_loader.sv
// Serial program loader and instruction fetch port for the 4-bit core.
// Latency: word written on the edge of its last bit; instr combinational from pc.
// Backpressure: none; one bit consumed per cycle with svalid=1, overflow words dropped.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   load_en         1 requests load mode (core held in reset)
//   sdata, svalid   serial program bits, MSB first
//   pc / instr      core fetch address / instruction (0 outside RUN or past loaded words)
//   core_reset      active-high reset to the core
//   word_count      words written since the last load start
//   overflow        sticky: a word completed while the store was full
module imem_loader
  import imem_pkg::*;
#(
  parameter int INSTR_W = imem_pkg::INSTR_W,
  parameter int ADDR_W  = imem_pkg::ADDR_W,
  parameter int DEPTH   = imem_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               sdata,
  input  logic               svalid,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               core_reset,
  output logic [ADDR_W:0]    word_count,
  output logic               overflow
);

  localparam int CW = (INSTR_W > 1) ? $clog2(INSTR_W) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(INSTR_W - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  loader_state_t      state_q, state_d;
  logic [INSTR_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      bitcnt_q, bitcnt_d;
  logic [ADDR_W:0]    wcnt_q, wcnt_d;
  logic               ovf_q, ovf_d;
  logic               core_rst_q, core_rst_d;

  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      core_rst_q <= core_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    wcnt_d     = wcnt_q;
    ovf_d      = ovf_q;
    core_rst_d = core_rst_q;
    mem_we     = 1'b0;
    // The completed word is the shifted value including this cycle's bit.
    mem_wdata  = {shreg_q[INSTR_W-2:0], sdata};

    unique case (state_q)
      IDLE: begin
        core_rst_d = 1'b1;
        if (load_en) begin
          state_d  = LOAD;
          wcnt_d   = '0;
          bitcnt_d = '0;
          ovf_d    = 1'b0;
        end
      end

      LOAD: begin
        if (!load_en) begin
          // Leaving load: any partial word and this cycle's bit are dropped.
          state_d    = RUN;
          bitcnt_d   = '0;
          core_rst_d = 1'b0;
        end else if (svalid) begin
          shreg_d = {shreg_q[INSTR_W-2:0], sdata};
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = '0;
            if (wcnt_q == FULL_CNT) begin
              ovf_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              wcnt_d = wcnt_q + 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end

      RUN: begin
        if (load_en) begin
          state_d    = LOAD;
          wcnt_d     = '0;
          bitcnt_d   = '0;
          ovf_d      = 1'b0;
          core_rst_d = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        core_rst_d = 1'b1;
      end
    endcase
  end

  imem_array #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wcnt_q[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  // Addresses not written since the last load start read as 0, which the
  // core treats as a no-effect instruction.
  assign instr = (state_q == RUN && {1'b0, pc} < wcnt_q) ? mem_rdata : '0;

  assign core_reset = core_rst_q;
  assign word_count = wcnt_q;
  assign overflow   = ovf_q;

endmodule
